// File: rtl/pulse_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_param_pkg
// Desc     : Shared constants for the pulse parameter link: framing bytes,
//            payload field offsets, power-on parameter defaults and the
//            frame FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_param_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         PAYLOAD_BYTES = 18;

  // Byte offsets of each field inside the payload (fields are MSB-first)
  localparam int OFF_PER      = 0;
  localparam int OFF_P1WID    = 4;
  localparam int OFF_DEL      = 6;
  localparam int OFF_P2WID    = 8;
  localparam int OFF_NUT_W    = 10;
  localparam int OFF_NUT_D    = 11;
  localparam int OFF_CP       = 13;
  localparam int OFF_P_BL     = 14;
  localparam int OFF_P_BL_OFF = 15;
  localparam int OFF_BL       = 17;

  // Power-on parameter set, shared with the pulse sequencer
  localparam logic [31:0] DEF_PER      = 32'd65536;
  localparam logic [15:0] DEF_P1WID    = 16'd30;
  localparam logic [15:0] DEF_DEL      = 16'd200;
  localparam logic [15:0] DEF_P2WID    = 16'd30;
  localparam logic [7:0]  DEF_NUT_W    = 8'd50;
  localparam logic [15:0] DEF_NUT_D    = 16'd300;
  localparam logic [7:0]  DEF_CP       = 8'd3;
  localparam logic [7:0]  DEF_P_BL     = 8'd50;
  localparam logic [15:0] DEF_P_BL_OFF = 16'd100;
  localparam logic        DEF_BL       = 1'b1;

  // The bl byte is the last payload byte and only its bit 0 is kept, so the
  // byte-wide staging store covers the payload minus that final byte.
  localparam int STAGE_BYTES = PAYLOAD_BYTES - 1;

  localparam logic [7:0] DEF_STAGE [STAGE_BYTES] = '{
    DEF_PER[31:24], DEF_PER[23:16], DEF_PER[15:8], DEF_PER[7:0],
    DEF_P1WID[15:8], DEF_P1WID[7:0],
    DEF_DEL[15:8], DEF_DEL[7:0],
    DEF_P2WID[15:8], DEF_P2WID[7:0],
    DEF_NUT_W,
    DEF_NUT_D[15:8], DEF_NUT_D[7:0],
    DEF_CP,
    DEF_P_BL,
    DEF_P_BL_OFF[15:8], DEF_P_BL_OFF[7:0]
  };

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Desc     : 8N1 UART byte receiver. Synchronises the serial line, detects the
//            start edge, rejects short start glitches, samples bits at their
//            centres and reports a good byte or a stop-bit framing error.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_line;
  logic          w_fall;
  logic          w_half;
  logic          w_full;

  assign w_line    = r_sync2;
  assign w_fall    = r_sync_d & ~r_sync2;
  assign w_half    = (r_cnt == HALF_LAST);
  assign w_full    = (r_cnt == BIT_LAST);
  assign byte_data = r_shift;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: a start that is high again at mid-bit is treated as a glitch
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = w_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Bit timer, LSB-first shift register and registered result strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: r_cnt <= '0;
        RX_START: begin
          r_cnt <= w_half ? '0 : r_cnt + 1'b1;
          r_bit <= '0;
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_line, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt      <= '0;
            byte_valid <= w_line;
            frame_err  <= ~w_line;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_param_rx.sv
`default_nettype none
// ============================================================================
// Module   : pulse_param_rx
// Desc     : Serial parameter receiver. Collects a framed, checksummed
//            parameter packet from the UART and commits the whole parameter
//            set at once with a single-cycle rx_done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_param_rx
  import pulse_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        rx_done,
  output logic        frame_err,
  output logic        chk_err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_err;

  frame_state_t r_state;
  frame_state_t w_next;
  logic [4:0]   r_index;
  logic [7:0]   r_sum;
  logic [7:0]   r_stage [STAGE_BYTES];
  logic         r_stage_bl;
  logic [TW-1:0] r_to_cnt;
  logic         r_chk_pend;
  logic         w_timeout;
  logic         w_last;
  logic         w_start;
  logic         w_store;
  logic         w_commit;
  logic         w_chk_fail;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (byte_err)
  );

  assign frame_err = byte_err;
  assign busy      = (r_state != ST_HUNT);
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CLKS));
  assign w_last    = (r_index == 5'(PAYLOAD_BYTES - 1));

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_next;
  end

  // Frame sequencing; a received byte wins over a timeout in the same cycle
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_store    = 1'b0;
    w_commit   = 1'b0;
    w_chk_fail = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (byte_valid && (byte_data == SYNC_BYTE)) begin
          w_start = 1'b1;
          w_next  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_err) begin
          w_next = ST_HUNT;
        end else if (byte_valid) begin
          w_store = 1'b1;
          if (w_last) w_next = ST_CHECK;
        end else if (w_timeout) begin
          w_next = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (byte_err) begin
          w_next = ST_HUNT;
        end else if (byte_valid) begin
          if (byte_data == r_sum) begin
            w_next = ST_COMMIT;
          end else begin
            w_chk_fail = 1'b1;
            w_next     = ST_HUNT;
          end
        end else if (w_timeout) begin
          w_next = ST_HUNT;
        end
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_HUNT;
      end
      default: w_next = ST_HUNT;
    endcase
  end

  // Staging store, byte index and running checksum; the last byte carries bl
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage    <= DEF_STAGE;
      r_stage_bl <= DEF_BL;
      r_index    <= '0;
      r_sum      <= '0;
    end else if (w_start) begin
      r_index <= '0;
      r_sum   <= '0;
    end else if (w_store) begin
      if (w_last) r_stage_bl       <= byte_data[0];
      else        r_stage[r_index] <= byte_data;
      r_index <= r_index + 5'd1;
      r_sum   <= r_sum + byte_data;
    end
  end

  // Inter-byte idle counter, only running while a frame is in progress
  always_ff @(posedge clk) begin
    if (reset || byte_valid ||
        !((r_state == ST_PAYLOAD) || (r_state == ST_CHECK))) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Parameter outputs: loaded from staging only when a frame commits
  always_ff @(posedge clk) begin
    if (reset) begin
      per      <= DEF_PER;
      p1wid    <= DEF_P1WID;
      del      <= DEF_DEL;
      p2wid    <= DEF_P2WID;
      nut_w    <= DEF_NUT_W;
      nut_d    <= DEF_NUT_D;
      cp       <= DEF_CP;
      p_bl     <= DEF_P_BL;
      p_bl_off <= DEF_P_BL_OFF;
      bl       <= DEF_BL;
    end else if (w_commit) begin
      per      <= {r_stage[OFF_PER], r_stage[OFF_PER+1],
                   r_stage[OFF_PER+2], r_stage[OFF_PER+3]};
      p1wid    <= {r_stage[OFF_P1WID], r_stage[OFF_P1WID+1]};
      del      <= {r_stage[OFF_DEL], r_stage[OFF_DEL+1]};
      p2wid    <= {r_stage[OFF_P2WID], r_stage[OFF_P2WID+1]};
      nut_w    <= r_stage[OFF_NUT_W];
      nut_d    <= {r_stage[OFF_NUT_D], r_stage[OFF_NUT_D+1]};
      cp       <= r_stage[OFF_CP];
      p_bl     <= r_stage[OFF_P_BL];
      p_bl_off <= {r_stage[OFF_P_BL_OFF], r_stage[OFF_P_BL_OFF+1]};
      bl       <= r_stage_bl;
    end
  end

  // Strobes; chk_err is delayed one cycle so it lines up with where rx_done would be
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done    <= 1'b0;
      r_chk_pend <= 1'b0;
      chk_err    <= 1'b0;
    end else begin
      rx_done    <= w_commit;
      r_chk_pend <= w_chk_fail;
      chk_err    <= r_chk_pend;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_param_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pulse_param_rx
// Desc     : Directed self-checking bench for pulse_param_rx. Frames are built
//            from intended parameter values; a per-cycle compare process holds
//            the committed parameter set and the strobe that must come next.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_param_rx;

  localparam int CPB = 16;
  localparam int TMO = 400;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic [7:0]  bl_byte;
  } frame_t;

  localparam frame_t DEF_F = '{32'd65536, 16'd30, 16'd200, 16'd30, 8'd50,
                               16'd300, 8'd3, 8'd50, 16'd100, 8'd1};

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        uart_rx = 1'b1;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, rx_done, frame_err, chk_err, busy;
  logic [136:0] dut_vec;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int exp_kind = 0;   // 0 none, 1 rx_done, 2 chk_err, 3 frame_err
  int exp_lo   = 0;
  int exp_hi   = 0;
  logic [136:0] pend_out;
  logic [136:0] model_out;

  pulse_param_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .per      (per),
    .p1wid    (p1wid),
    .del      (del),
    .p2wid    (p2wid),
    .nut_w    (nut_w),
    .nut_d    (nut_d),
    .cp       (cp),
    .p_bl     (p_bl),
    .p_bl_off (p_bl_off),
    .bl       (bl),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .chk_err  (chk_err),
    .busy     (busy)
  );

  assign dut_vec = {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl};

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pbyte(input frame_t f, input int k);
    logic [143:0] v;
    v = f;
    v = v << (8 * k);
    return v[143:136];
  endfunction

  function automatic logic [136:0] expv(input frame_t f);
    return {f.per, f.p1wid, f.del, f.p2wid, f.nut_w, f.nut_d, f.cp,
            f.p_bl, f.p_bl_off, f.bl_byte[0]};
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: committed-parameter model and expected-strobe tracking
  always @(negedge clk) begin
    if (reset) begin
      model_out = expv(DEF_F);
      exp_kind  = 0;
    end else begin
      if (rx_done || chk_err || frame_err) begin
        int kind;
        kind = rx_done ? 1 : (chk_err ? 2 : 3);
        check("single_strobe", 144'($countones({rx_done, chk_err, frame_err})), 144'd1);
        check("strobe_kind", 144'(kind), 144'(exp_kind));
        if (exp_kind != 0)
          check("strobe_window", 144'(cyc >= exp_lo && cyc <= exp_hi), 144'd1);
        if (rx_done) check("busy_low_at_done", 144'(busy), 144'd0);
        if (rx_done && exp_kind == 1) model_out = pend_out;
        exp_kind = 0;
      end else if (exp_kind != 0 && cyc > exp_hi) begin
        check("strobe_missing", 144'd0, 144'(exp_kind));
        exp_kind = 0;
      end
      check("params", 144'(dut_vec), 144'(model_out));
    end
  end

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int bits);
    uart_rx = 1'b1;
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask

  // One 8N1 byte; when kind is non-zero the named strobe is expected during the stop bit
  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int kind,
                           input logic [136:0] pout);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (kind != 0) begin
      exp_lo   = cyc + CPB / 2;
      exp_hi   = cyc + CPB + 4;
      pend_out = pout;
      exp_kind = kind;
    end
    send_bit(stop_ok);
  endtask

  task automatic send_frame(input frame_t f, input int chk_delta);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(8'hA5, 1'b1, 0, '0);
    for (int k = 0; k < 18; k++) begin
      sum = sum + pbyte(f, k);
      send_byte(pbyte(f, k), 1'b1, 0, '0);
    end
    send_byte(sum + 8'(chk_delta), 1'b1, (chk_delta == 0) ? 1 : 2, expv(f));
  endtask

  initial begin
    frame_t f1, f2, f3, fa;
    f1 = '{32'h0001_0000, 16'd40, 16'd500, 16'd80, 8'd50, 16'd300, 8'd1, 8'd50, 16'd100, 8'd0};
    f2 = '{32'h0012_3456, 16'd1000, 16'd0, 16'hFFFF, 8'hFF, 16'd1, 8'h00, 8'h80, 16'hFFFF, 8'h00};
    f3 = '{32'hFFFF_FFFF, 16'h1357, 16'h2468, 16'h0102, 8'h09, 16'hBEEF, 8'h42, 8'h24, 16'h00FE, 8'h01};
    fa = '{32'hA5A5_0102, 16'h00A5, 16'hA500, 16'h1234, 8'hA5, 16'h0203, 8'h07, 8'h10, 16'h0A0B, 8'hA5};

    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_per", per, 32'd65536);
    check("rst_p1wid", p1wid, 16'd30);
    check("rst_del", del, 16'd200);
    check("rst_p2wid", p2wid, 16'd30);
    check("rst_nut_w", nut_w, 8'd50);
    check("rst_nut_d", nut_d, 16'd300);
    check("rst_cp", cp, 8'd3);
    check("rst_p_bl", p_bl, 8'd50);
    check("rst_p_bl_off", p_bl_off, 16'd100);
    check("rst_bl", bl, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {rx_done, chk_err, frame_err}, 3'b000);

    // Bad checksum: chk_err, defaults kept
    send_frame(f1, 1);
    idle(2);
    check("badchk_p1wid", p1wid, 16'd30);
    check("badchk_del", del, 16'd200);
    check("badchk_busy", busy, 1'b0);

    // Valid frame
    send_frame(f1, 0);
    idle(2);
    check("f1_per", per, 32'h0001_0000);
    check("f1_p1wid", p1wid, 16'd40);
    check("f1_del", del, 16'd500);
    check("f1_p2wid", p2wid, 16'd80);
    check("f1_cp", cp, 8'd1);
    check("f1_bl", bl, 1'b0);

    // Short low glitch, then two frames back-to-back
    uart_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(3);
    check("glitch_busy", busy, 1'b0);
    send_frame(f2, 0);
    send_frame(f3, 0);
    idle(2);
    check("f3_per", per, 32'hFFFF_FFFF);
    check("f3_nut_d", nut_d, 16'hBEEF);

    // Bad stop bit on payload byte 5
    send_byte(8'hA5, 1'b1, 0, '0);
    for (int k = 0; k < 5; k++) send_byte(pbyte(f2, k), 1'b1, 0, '0);
    send_byte(pbyte(f2, 5), 1'b0, 3, '0);
    idle(2);
    check("ferr_busy", busy, 1'b0);
    check("ferr_per_kept", per, 32'hFFFF_FFFF);
    send_frame(f2, 0);
    idle(2);
    check("f2_per", per, 32'h0012_3456);
    check("f2_p_bl_off", p_bl_off, 16'hFFFF);

    // Stall after 10 payload bytes
    send_byte(8'hA5, 1'b1, 0, '0);
    for (int k = 0; k < 10; k++) send_byte(pbyte(f1, k), 1'b1, 0, '0);
    check("stall_busy_before", busy, 1'b1);
    uart_rx = 1'b1;
    repeat (TMO + 1) @(posedge clk);
    #1;
    check("stall_busy_after", busy, 1'b0);
    check("stall_per_kept", per, 32'h0012_3456);

    // Payload with 0xA5 data, then reset part-way through a second frame
    send_frame(fa, 0);
    idle(2);
    check("fa_per", per, 32'hA5A5_0102);
    check("fa_p1wid", p1wid, 16'h00A5);
    check("fa_del", del, 16'hA500);
    check("fa_nut_w", nut_w, 8'hA5);
    check("fa_bl", bl, 1'b1);
    send_byte(8'hA5, 1'b1, 0, '0);
    for (int k = 0; k < 6; k++) send_byte(pbyte(f3, k), 1'b1, 0, '0);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("midframe_busy", busy, 1'b1);
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_per", per, 32'd65536);
    check("post_rst_p1wid", p1wid, 16'd30);
    check("post_rst_nut_w", nut_w, 8'd50);
    idle(25);
    check("post_rst_idle_busy", busy, 1'b0);
    check("no_pending_strobe", exp_kind, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
